// File: rtl/max7219_display.sv
// Drives a daisy chain of MAX7219 7-segment drivers over 3-wire SPI: one init pass,
// then endless refresh of 8 hex digits per chip from a snapshot of the frame bytes.
module max7219_display #(
    parameter int NUM_CASCADES = 2,
    parameter int INTENSITY    = 1,
    parameter int CLK_DIV      = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  frame [4*NUM_CASCADES],
    output logic        spi_clk,
    output logic        dout,
    output logic        cs,
    output logic        stop,
    output logic [10:1] pin
);

    localparam int N  = 16 * NUM_CASCADES;
    localparam int NB = 4 * NUM_CASCADES;
    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam int BW = $clog2(N + 1);

    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_INIT = BW'(N - 1);
    localparam logic [3:0]    INT4      = 4'(INTENSITY);

    typedef enum logic [2:0] {
        S_GAP,
        S_START,
        S_LOW,
        S_HIGH,
        S_END
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bits_left;
    logic [3:0]    cmd;
    logic          init_done;
    logic [N-1:0]  word;
    logic [N-1:0]  shreg;
    logic [7:0]    snap [NB];
    logic [7:0]    sel_byte;
    logic [2:0]    dsel;
    logic          half_done;
    logic          gap_done;
    logic          shift_now;

    function automatic logic [7:0] hex_font(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h7E;
            4'h1: seg = 8'h30;
            4'h2: seg = 8'h6D;
            4'h3: seg = 8'h79;
            4'h4: seg = 8'h33;
            4'h5: seg = 8'h5B;
            4'h6: seg = 8'h5F;
            4'h7: seg = 8'h70;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h7B;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h1F;
            4'hC: seg = 8'h4E;
            4'hD: seg = 8'h3D;
            4'hE: seg = 8'h4F;
            default: seg = 8'h47;
        endcase
        return seg;
    endfunction

    assign half_done = (cnt == HALF_LAST);
    assign gap_done  = (state == S_GAP) && (cnt == GAP_LAST);
    assign shift_now = (state == S_HIGH) && half_done && (bits_left != '0);

    // Digit index counted from reg 8 (0) down to reg 1 (7); selects byte and nibble.
    assign dsel = 3'(4'd12 - cmd);

    // Chip k occupies word[16k +: 16]; the highest slice is shifted first and ends in the far chip.
    always_comb begin
        word     = '0;
        sel_byte = '0;
        for (int k = 0; k < NUM_CASCADES; k++) begin
            case (dsel[2:1])
                2'd0:    sel_byte = snap[4*k];
                2'd1:    sel_byte = snap[4*k+1];
                2'd2:    sel_byte = snap[4*k+2];
                default: sel_byte = snap[4*k+3];
            endcase
            case (cmd)
                4'd0:    word[16*k +: 16] = 16'h0C01;
                4'd1:    word[16*k +: 16] = 16'h0900;
                4'd2:    word[16*k +: 16] = 16'h0B07;
                4'd3:    word[16*k +: 16] = {12'h0A0, INT4};
                4'd4:    word[16*k +: 16] = 16'h0F00;
                default: word[16*k +: 16] = {4'h0, cmd - 4'd4,
                             hex_font(dsel[0] ? sel_byte[3:0] : sel_byte[7:4])};
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= S_GAP;
            cnt       <= '0;
            bits_left <= '0;
            cmd       <= '0;
            init_done <= 1'b0;
            spi_clk   <= 1'b0;
            dout      <= 1'b0;
            cs        <= 1'b1;
            stop      <= 1'b1;
        end else begin
            case (state)
                S_GAP: begin
                    if (gap_done) begin
                        cnt   <= '0;
                        state <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    cs        <= 1'b0;
                    stop      <= 1'b0;
                    dout      <= word[N-1];
                    bits_left <= BITS_INIT;
                    cnt       <= '0;
                    state     <= S_LOW;
                end
                S_LOW: begin
                    if (half_done) begin
                        cnt     <= '0;
                        spi_clk <= 1'b1;
                        state   <= S_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (half_done) begin
                        cnt     <= '0;
                        spi_clk <= 1'b0;
                        if (bits_left != '0) begin
                            dout      <= shreg[N-1];
                            bits_left <= bits_left - 1'b1;
                            state     <= S_LOW;
                        end else begin
                            state <= S_END;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (half_done) begin
                        cnt   <= '0;
                        cs    <= 1'b1;
                        stop  <= 1'b1;
                        dout  <= 1'b0;
                        state <= S_GAP;
                        if (cmd == 4'd4) init_done <= 1'b1;
                        cmd <= (cmd == 4'd12) ? 4'd5 : cmd + 4'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_GAP;
            endcase
        end
    end

    // Datapath: frame snapshot taken just before the reg-1 word, and the outgoing shift register.
    always_ff @(posedge sysclk) begin
        if (gap_done && (cmd == 4'd5)) begin
            for (int i = 0; i < NB; i++) snap[i] <= frame[i];
        end
        if (state == S_START) begin
            shreg <= {word[N-2:0], 1'b0};
        end else if (shift_now) begin
            shreg <= {shreg[N-2:0], 1'b0};
        end
    end

    assign pin = {5'b00000, init_done, stop, cs, dout, spi_clk};

endmodule

// File: tb/tb_max7219_display.sv
// Directed bench for max7219_display: reset/abort behaviour, init words, digit words
// from two frame snapshots, and SPI timing rules observed on every window.
module tb_max7219_display;

    localparam int CLK_DIV = 4;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [7:0]  frame [8];
    logic        spi_clk;
    logic        dout;
    logic        cs;
    logic        stop;
    logic [10:1] pin;

    int total = 0;
    int bad   = 0;

    logic [31:0] cap = '0;
    logic [31:0] win_q [$];
    int          cnt_q [$];

    logic prev_sc   = 1'b0;
    logic prev_dout = 1'b0;
    logic prev_cs   = 1'b1;
    int   hi_len    = 0;
    int   lo_len    = 0;
    int   cs_hi_len = 0;
    int   win_rises = 0;
    int   v_dout    = 0;
    int   v_cs      = 0;
    int   v_hi      = 0;
    int   v_lo      = 0;
    int   v_gap     = 0;

    max7219_display #(
        .NUM_CASCADES(2),
        .INTENSITY   (1),
        .CLK_DIV     (CLK_DIV)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .frame  (frame),
        .spi_clk(spi_clk),
        .dout   (dout),
        .cs     (cs),
        .stop   (stop),
        .pin    (pin)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge spi_clk) begin
        if (!cs) cap <= {cap[30:0], dout};
    end

    always @(posedge cs) begin
        if (!reset) win_q.push_back(cap);
    end

    always @(negedge sysclk) begin
        if (reset) begin
            hi_len    <= 0;
            lo_len    <= 0;
            cs_hi_len <= 0;
            win_rises <= 0;
        end else begin
            if (spi_clk && (dout !== prev_dout)) v_dout <= v_dout + 1;
            if ((spi_clk || prev_sc) && (cs !== prev_cs)) v_cs <= v_cs + 1;
            if (spi_clk) begin
                hi_len <= hi_len + 1;
            end else begin
                hi_len <= 0;
                if (prev_sc && hi_len != CLK_DIV) v_hi <= v_hi + 1;
            end
            if (!spi_clk && !cs) lo_len <= lo_len + 1;
            else lo_len <= 0;
            if (spi_clk && !prev_sc) begin
                if (lo_len != CLK_DIV) v_lo <= v_lo + 1;
                win_rises <= win_rises + 1;
            end
            if (cs) cs_hi_len <= cs_hi_len + 1;
            else cs_hi_len <= 0;
            if (!cs && prev_cs && cs_hi_len < 2*CLK_DIV) v_gap <= v_gap + 1;
            if (cs && !prev_cs) begin
                cnt_q.push_back(win_rises);
                win_rises <= 0;
            end
        end
        prev_sc   <= spi_clk;
        prev_dout <= dout;
        prev_cs   <= cs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_win(input int n);
        int c = 0;
        while (win_q.size() < n && c < 10000) begin
            @(negedge sysclk);
            c++;
        end
        chk($sformatf("reach_window_%0d", n), 32'(win_q.size() >= n), 32'd1);
    endtask

    logic [31:0] init_exp [5] = '{32'h0C010C01, 32'h09000900, 32'h0B070B07,
                                  32'h0A010A01, 32'h0F000F00};
    // Windows 6..22: 6..13 from the first frame, 14..22 from the second.
    logic [31:0] dig_exp [17] = '{
        32'h017E017F, 32'h02470270, 32'h034F035F, 32'h043D045B,
        32'h054E0533, 32'h061F0679, 32'h0777076D, 32'h087B0830,
        32'h017B0170, 32'h023D0270, 32'h031F034E, 32'h045F0479,
        32'h056D0547, 32'h064F067E, 32'h0730075B, 32'h087F0877,
        32'h017B0170};

    initial begin
        int c;
        reset = 1'b1;
        frame = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        repeat (5) @(negedge sysclk);
        chk("rst_spi_clk", 32'(spi_clk), 32'd0);
        chk("rst_cs",      32'(cs),      32'd1);
        chk("rst_stop",    32'(stop),    32'd1);
        chk("rst_dout",    32'(dout),    32'd0);
        chk("rst_pin",     32'(pin),     32'(10'b0000001100));

        reset = 1'b0;
        c = 0;
        while (cs !== 1'b0 && c < 100) begin
            @(negedge sysclk);
            c++;
        end
        chk("first_fall_seen",  32'(cs), 32'd0);
        chk("first_fall_delay", 32'(c >= 2*CLK_DIV && c <= 2*CLK_DIV + 1), 32'd1);
        chk("busy_stop",        32'(stop), 32'd0);

        repeat (20) @(negedge sysclk);
        chk("midword_cs_low", 32'(cs), 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_cs",      32'(cs),      32'd1);
        chk("abort_stop",    32'(stop),    32'd1);
        chk("abort_spi_clk", 32'(spi_clk), 32'd0);
        repeat (3) @(negedge sysclk);
        win_q.delete();
        cnt_q.delete();
        reset = 1'b0;

        wait_win(4);
        chk("init_done_before_w5", 32'(pin[5]), 32'd0);
        wait_win(5);
        chk("init_done_after_w5", 32'(pin[5]), 32'd1);
        for (int i = 0; i < 5; i++)
            chk($sformatf("init_window_%0d", i + 1), win_q[i], init_exp[i]);

        wait_win(7);
        frame = '{8'hA5, 8'h0F, 8'h3C, 8'h77, 8'h81, 8'hE2, 8'h6B, 8'hD9};

        wait_win(22);
        @(negedge sysclk);
        chk("init_done_held", 32'(pin[5]), 32'd1);
        for (int i = 0; i < 17; i++)
            chk($sformatf("digit_window_%0d", i + 6), win_q[i + 5], dig_exp[i]);

        chk("rise_count_entries", 32'(cnt_q.size() >= 22), 32'd1);
        for (int i = 0; i < cnt_q.size(); i++)
            chk($sformatf("rises_window_%0d", i + 1), 32'(cnt_q[i]), 32'd32);
        chk("dout_change_while_high", 32'(v_dout), 32'd0);
        chk("cs_change_while_high",   32'(v_cs),   32'd0);
        chk("spi_high_width",         32'(v_hi),   32'd0);
        chk("spi_low_width",          32'(v_lo),   32'd0);
        chk("cs_gap_width",           32'(v_gap),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
